execute_stage_mc: RTL and testbench

//  Parametrised execute stage: operand-B select, single-cycle ALU and an iterative multiplier.

---
 rtl/execute_stage_mc_pkg.sv | 55 +++++
 rtl/execute_stage_mc_if.sv | 37 +++
 rtl/execute_stage_mc_mul.sv | 65 ++++++
 rtl/execute_stage_mc.sv | 150 +++++++++++++++
 tb/tb_execute_stage_mc.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/execute_stage_mc_pkg.sv
// Package: exec_pkg
// Shared encodings for the execute stage: condition codes, ALU op codes,
// operand-B source select, FSM states, flag bit positions and the
// condition evaluator used for B.cond.
package exec_pkg;

  typedef enum logic [3:0] {
    COND_EQ, COND_NE, COND_HS, COND_LO, COND_MI, COND_PL, COND_VS, COND_VC,
    COND_HI, COND_LS, COND_GE, COND_LT, COND_GT, COND_LE, COND_AL, COND_NV
  } cond_e;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_ORR, ALU_EOR, ALU_LSL, ALU_LSR, ALU_ASR
  } alu_op_e;

  typedef enum logic [1:0] {
    SRC_REG, SRC_IMM12, SRC_IMM9, SRC_ZERO
  } alu_src_e;

  typedef enum logic [1:0] {
    ST_IDLE, ST_MUL, ST_DONE
  } state_e;

  // Bit positions inside the {N,C,V,Z} flag vector
  localparam int FLAG_N = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 0;

  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] f);
    logic n, c, v, z;
    n = f[FLAG_N];
    c = f[FLAG_C];
    v = f[FLAG_V];
    z = f[FLAG_Z];
    case (cond_e'(cond))
      COND_EQ: cond_eval = z;
      COND_NE: cond_eval = ~z;
      COND_HS: cond_eval = c;
      COND_LO: cond_eval = ~c;
      COND_MI: cond_eval = n;
      COND_PL: cond_eval = ~n;
      COND_VS: cond_eval = v;
      COND_VC: cond_eval = ~v;
      COND_HI: cond_eval = c & ~z;
      COND_LS: cond_eval = ~c | z;
      COND_GE: cond_eval = (n == v);
      COND_LT: cond_eval = (n != v);
      COND_GT: cond_eval = ~z & (n == v);
      COND_LE: cond_eval = z | (n != v);
      default: cond_eval = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/execute_stage_mc_if.sv
// Interface: execute_stage_mc_if
// Bundles the op-side (in_*) and result-side (out_*) handshakes of the
// execute stage together with operands, control and result fields.
//  master : the surrounding pipeline (drives ops, consumes results)
//  slave  : the execute stage itself
interface execute_stage_mc_if #(
  parameter int DATA_W = 64
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] data_a;
  logic [DATA_W-1:0] data_b;
  logic [DATA_W-1:0] imm12_ext;
  logic [DATA_W-1:0] imm9_ext;
  logic [1:0]        alu_src;
  logic [2:0]        alu_op;
  logic              is_mul;
  logic              flag_write;
  logic [3:0]        cond;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] alu_out;
  logic [3:0]        flags;
  logic              cond_taken;

  modport master (
    output in_valid, data_a, data_b, imm12_ext, imm9_ext, alu_src, alu_op,
           is_mul, flag_write, cond, out_ready,
    input  in_ready, out_valid, alu_out, flags, cond_taken
  );

  modport slave (
    input  in_valid, data_a, data_b, imm12_ext, imm9_ext, alu_src, alu_op,
           is_mul, flag_write, cond, out_ready,
    output in_ready, out_valid, alu_out, flags, cond_taken
  );
endinterface

// File: rtl/execute_stage_mc_mul.sv
// Module: mul_iter
// Iterative shift-add multiplier retiring MUL_ITER multiplier bits per cycle.
// Ports:
//  clk, reset   clock / async active-high reset (aborts a running multiply)
//  start        load operands a, b and begin DATA_W/MUL_ITER iterations
//  busy         iterations in progress
//  done         final iteration is being retired this cycle
//  product      accumulator value after this cycle's iteration; when done=1
//               it is the low DATA_W bits of a*b
module mul_iter #(
  parameter int DATA_W   = 64,
  parameter int MUL_ITER = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product
);
  localparam int N_ITER = DATA_W / MUL_ITER;
  localparam int CNT_W  = $clog2(N_ITER + 1);

  logic [CNT_W-1:0]  cnt_p0;
  logic [DATA_W-1:0] mcand_p0, mplier_p0, acc_p0, acc_d;

  always_comb begin
    acc_d = acc_p0;
    for (int j = 0; j < MUL_ITER; j++) begin
      if (mplier_p0[j]) acc_d = acc_d + (mcand_p0 << j);
    end
  end

  // ---- iteration control ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy   <= 1'b0;
      cnt_p0 <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt_p0 <= CNT_W'(N_ITER);
    end else if (busy) begin
      cnt_p0 <= cnt_p0 - CNT_W'(1);
      if (cnt_p0 == CNT_W'(1)) busy <= 1'b0;
    end
  end

  // ---- datapath; start always reloads, so a reset-aborted product is never seen ----
  always_ff @(posedge clk) begin
    if (start) begin
      acc_p0    <= '0;
      mcand_p0  <= a;
      mplier_p0 <= b;
    end else if (busy) begin
      acc_p0    <= acc_d;
      mcand_p0  <= mcand_p0 << MUL_ITER;
      mplier_p0 <= mplier_p0 >> MUL_ITER;
    end
  end

  assign done    = busy & (cnt_p0 == CNT_W'(1));
  assign product = acc_d;
endmodule

// File: rtl/execute_stage_mc.sv
// Module: execute_stage_mc
// Execute stage: operand-B select, single-cycle ALU, iterative multiplier,
// {N,C,V,Z} flag register and full 16-way condition evaluation.
// Ports:
//  clk    clock, rising edge
//  reset  asynchronous, active-high
//  bus    execute_stage_mc_if.slave: in_valid/in_ready op handshake with
//         operands, imm extensions, alu_src, alu_op, is_mul, flag_write, cond;
//         out_valid/out_ready result handshake with alu_out, flags, cond_taken
module execute_stage_mc
  import exec_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int MUL_ITER = 1
) (
  input logic               clk,
  input logic               reset,
  execute_stage_mc_if.slave bus
);
  localparam int SH_W = $clog2(DATA_W);

  state_e                   state_q, state_d;
  logic                     accept, consume, mul_start, mul_busy, mul_done;
  logic [DATA_W-1:0]        mul_prod;
  logic signed [DATA_W-1:0] a_s, b_s, res;
  logic [DATA_W:0]          sum;
  logic                     c_out, v_out, ct_alu, ct_mul, flags_en;
  logic [3:0]               flags_alu, flags_mul, flags_d;
  logic [3:0]               cond_p0;
  logic                     fw_p0;

  // A new op only enters from IDLE, and only if the result slot is free or draining
  assign accept       = bus.in_valid & bus.in_ready;
  assign consume      = bus.out_valid & bus.out_ready;
  assign bus.in_ready = (state_q == ST_IDLE) & ~mul_busy & (~bus.out_valid | bus.out_ready);
  assign mul_start    = accept & bus.is_mul;

  assign a_s = bus.data_a;
  always_comb begin
    case (alu_src_e'(bus.alu_src))
      SRC_REG:   b_s = bus.data_b;
      SRC_IMM12: b_s = bus.imm12_ext;
      SRC_IMM9:  b_s = bus.imm9_ext;
      default:   b_s = '0;
    endcase
  end

  always_comb begin
    sum   = '0;
    res   = '0;
    c_out = 1'b0;
    v_out = 1'b0;
    case (alu_op_e'(bus.alu_op))
      ALU_ADD: begin
        sum   = {1'b0, a_s} + {1'b0, b_s};
        res   = sum[DATA_W-1:0];
        c_out = sum[DATA_W];
        v_out = (a_s[DATA_W-1] == b_s[DATA_W-1]) && (res[DATA_W-1] != a_s[DATA_W-1]);
      end
      ALU_SUB: begin
        // C is "no borrow": carry out of a + ~b + 1
        sum   = {1'b0, a_s} + {1'b0, ~b_s} + (DATA_W+1)'(1);
        res   = sum[DATA_W-1:0];
        c_out = sum[DATA_W];
        v_out = (a_s[DATA_W-1] != b_s[DATA_W-1]) && (res[DATA_W-1] != a_s[DATA_W-1]);
      end
      ALU_AND: res = a_s & b_s;
      ALU_ORR: res = a_s | b_s;
      ALU_EOR: res = a_s ^ b_s;
      ALU_LSL: res = a_s << b_s[SH_W-1:0];
      ALU_LSR: res = a_s >> b_s[SH_W-1:0];
      default: res = a_s >>> b_s[SH_W-1:0];
    endcase
  end

  assign flags_alu = {res[DATA_W-1], c_out, v_out, (res == '0)};
  // Multiply only defines N and Z; C and V carry over from the flag register
  assign flags_mul = {mul_prod[DATA_W-1], bus.flags[FLAG_C], bus.flags[FLAG_V], (mul_prod == '0)};
  assign ct_alu    = cond_eval(bus.cond, bus.flag_write ? flags_alu : bus.flags);
  assign ct_mul    = cond_eval(cond_p0, fw_p0 ? flags_mul : bus.flags);

  mul_iter #(.DATA_W(DATA_W), .MUL_ITER(MUL_ITER)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (bus.data_a),
    .b       (b_s),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  // Cond and flag_write of a multiply are needed at completion, not at accept
  always_ff @(posedge clk) begin
    if (mul_start) begin
      cond_p0 <= bus.cond;
      fw_p0   <= bus.flag_write;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (mul_start) state_d = ST_MUL;
      ST_MUL:  if (mul_done)  state_d = ST_DONE;
      ST_DONE: if (consume)   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    flags_en = 1'b0;
    flags_d  = flags_alu;
    if (accept && !bus.is_mul && bus.flag_write) begin
      flags_en = 1'b1;
    end else if (state_q == ST_MUL && mul_done && fw_p0) begin
      flags_en = 1'b1;
      flags_d  = flags_mul;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         bus.flags <= '0;
    else if (flags_en) bus.flags <= flags_d;
  end

  // ---- EX result register (EX/MEM boundary) ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.out_valid  <= 1'b0;
      bus.alu_out    <= '0;
      bus.cond_taken <= 1'b0;
    end else if (accept && !bus.is_mul) begin
      bus.out_valid  <= 1'b1;
      bus.alu_out    <= res;
      bus.cond_taken <= ct_alu;
    end else if (state_q == ST_MUL && mul_done) begin
      bus.out_valid  <= 1'b1;
      bus.alu_out    <= mul_prod;
      bus.cond_taken <= ct_mul;
    end else if (consume) begin
      bus.out_valid  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_execute_stage_mc.sv
module tb_execute_stage_mc;
  import exec_pkg::*;

  localparam int W = 64;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  execute_stage_mc_if #(.DATA_W(W)) bus ();

  execute_stage_mc #(.DATA_W(W), .MUL_ITER(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic put(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] src,
                     input logic [2:0] op, input logic mul, input logic fw, input logic [3:0] cnd);
    bus.in_valid   = 1'b1;
    bus.data_a     = a;
    bus.data_b     = b;
    bus.alu_src    = src;
    bus.alu_op     = op;
    bus.is_mul     = mul;
    bus.flag_write = fw;
    bus.cond       = cnd;
  endtask

  task automatic idle_in();
    bus.in_valid   = 1'b0;
    bus.is_mul     = 1'b0;
    bus.flag_write = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.alu_out !== 64'd0) begin bad++; $display("FAIL reset_alu_out got=%h want=0", bus.alu_out); end
    total++; if (bus.flags !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b want=0000", bus.flags); end
    total++; if (bus.cond_taken !== 1'b0) begin bad++; $display("FAIL reset_cond_taken got=%b want=0", bus.cond_taken); end
    reset = 1'b0;
    step();
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
  endtask

  task automatic test_add_overflow();
    put(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, SRC_REG, ALU_ADD, 1'b0, 1'b1, COND_VS);
    step();
    idle_in();
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL addv_valid got=%b want=1", bus.out_valid); end
    total++; if (bus.alu_out !== 64'h8000_0000_0000_0000) begin bad++; $display("FAIL addv_result got=%h want=8000000000000000", bus.alu_out); end
    total++; if (bus.flags !== 4'b1010) begin bad++; $display("FAIL addv_flags got=%b want=1010", bus.flags); end
    total++; if (bus.cond_taken !== 1'b1) begin bad++; $display("FAIL addv_cond got=%b want=1", bus.cond_taken); end
    step();
  endtask

  task automatic test_subs_cond();
    put(64'd5, 64'd5, SRC_REG, ALU_SUB, 1'b0, 1'b1, COND_NE);
    step();
    total++; if (bus.alu_out !== 64'd0) begin bad++; $display("FAIL subs_result got=%h want=0", bus.alu_out); end
    total++; if (bus.flags !== 4'b0101) begin bad++; $display("FAIL subs_flags got=%b want=0101", bus.flags); end
    total++; if (bus.cond_taken !== 1'b0) begin bad++; $display("FAIL subs_cond_ne got=%b want=0", bus.cond_taken); end
    put(64'd1, 64'd1, SRC_REG, ALU_ADD, 1'b0, 1'b0, COND_EQ);
    step();
    idle_in();
    total++; if (bus.alu_out !== 64'd2) begin bad++; $display("FAIL beq_result got=%h want=2", bus.alu_out); end
    total++; if (bus.flags !== 4'b0101) begin bad++; $display("FAIL beq_flags_kept got=%b want=0101", bus.flags); end
    total++; if (bus.cond_taken !== 1'b1) begin bad++; $display("FAIL beq_stored_z got=%b want=1", bus.cond_taken); end
    step();
  endtask

  // Set flags with one op, then evaluate all 16 conds against the stored flags
  task automatic test_cond_table(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                                 input logic [3:0] fexp, input logic [15:0] texp);
    put(a, b, SRC_REG, op, 1'b0, 1'b1, COND_AL);
    step();
    total++; if (bus.flags !== fexp) begin bad++; $display("FAIL cond_setup_flags got=%b want=%b", bus.flags, fexp); end
    for (int i = 0; i < 16; i++) begin
      put(64'd0, 64'd0, SRC_REG, ALU_ADD, 1'b0, 1'b0, 4'(i));
      step();
      total++;
      if (bus.cond_taken !== texp[i]) begin
        bad++; $display("FAIL cond_%0d flags=%b got=%b want=%b", i, fexp, bus.cond_taken, texp[i]);
      end
    end
    idle_in();
    step();
  endtask

  task automatic test_ops();
    logic [W-1:0] ta [7];
    logic [W-1:0] tbv[7];
    logic [W-1:0] te [7];
    logic [1:0]   ts [7];
    logic [2:0]   to [7];
    bus.imm12_ext = 64'h0F0F;
    bus.imm9_ext  = 64'h000F;
    ta[0] = 64'hF0F0;                tbv[0] = 64'hFF00; ts[0] = SRC_REG;   to[0] = ALU_AND; te[0] = 64'hF000;
    ta[1] = 64'hF0F0;                tbv[1] = 64'hDEAD; ts[1] = SRC_IMM12; to[1] = ALU_ORR; te[1] = 64'hFFFF;
    ta[2] = 64'h00FF;                tbv[2] = 64'hDEAD; ts[2] = SRC_IMM9;  to[2] = ALU_EOR; te[2] = 64'h00F0;
    ta[3] = 64'd1;                   tbv[3] = 64'd4;    ts[3] = SRC_REG;   to[3] = ALU_LSL; te[3] = 64'd16;
    ta[4] = 64'h8000_0000_0000_0000; tbv[4] = 64'd63;   ts[4] = SRC_REG;   to[4] = ALU_LSR; te[4] = 64'd1;
    ta[5] = 64'h8000_0000_0000_0000; tbv[5] = 64'd63;   ts[5] = SRC_REG;   to[5] = ALU_ASR; te[5] = 64'hFFFF_FFFF_FFFF_FFFF;
    ta[6] = 64'h55;                  tbv[6] = 64'd123;  ts[6] = SRC_ZERO;  to[6] = ALU_ADD; te[6] = 64'h55;
    for (int i = 0; i < 7; i++) begin
      put(ta[i], tbv[i], ts[i], to[i], 1'b0, 1'b0, COND_AL);
      step();
      total++;
      if (bus.alu_out !== te[i]) begin
        bad++; $display("FAIL op_%0d got=%h want=%h", i, bus.alu_out, te[i]);
      end
    end
    idle_in();
    step();
  endtask

  task automatic test_mul();
    int n = 0;
    int ready_bad = 0;
    // Flags 0111 beforehand so preserved C,V are visible
    put(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, SRC_REG, ALU_ADD, 1'b0, 1'b1, COND_AL);
    step();
    put(64'd3, 64'd7, SRC_REG, ALU_ADD, 1'b1, 1'b1, COND_VS);
    step();
    idle_in();
    while (bus.out_valid !== 1'b1 && n < 200) begin
      if (bus.in_ready !== 1'b0) ready_bad++;
      step();
      n++;
    end
    total++; if (n != 64) begin bad++; $display("FAIL mul_latency got=%0d want=64", n); end
    total++; if (ready_bad != 0) begin bad++; $display("FAIL mul_in_ready_high got=%0d cycles want=0", ready_bad); end
    total++; if (bus.alu_out !== 64'd21) begin bad++; $display("FAIL mul_result got=%h want=15", bus.alu_out); end
    total++; if (bus.flags !== 4'b0110) begin bad++; $display("FAIL mul_flags got=%b want=0110", bus.flags); end
    total++; if (bus.cond_taken !== 1'b1) begin bad++; $display("FAIL mul_cond_vs got=%b want=1", bus.cond_taken); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL mul_done_in_ready got=%b want=0", bus.in_ready); end
    step();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mul_consumed got=%b want=0", bus.out_valid); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL mul_back_idle got=%b want=1", bus.in_ready); end
  endtask

  task automatic test_stall();
    int stall_bad = 0;
    bus.out_ready = 1'b0;
    bus.imm12_ext = 64'd20;
    bus.imm9_ext  = 64'd4;
    put(64'd10, 64'hDEAD, SRC_IMM12, ALU_ADD, 1'b0, 1'b0, COND_AL);
    step();
    put(64'd9, 64'hDEAD, SRC_IMM9, ALU_SUB, 1'b0, 1'b0, COND_AL);
    for (int i = 0; i < 5; i++) begin
      if (bus.out_valid !== 1'b1 || bus.alu_out !== 64'd30 || bus.in_ready !== 1'b0) stall_bad++;
      step();
    end
    total++; if (stall_bad != 0) begin bad++; $display("FAIL stall_hold got=%0d bad cycles want=0", stall_bad); end
    bus.out_ready = 1'b1;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL stall_release_ready got=%b want=1", bus.in_ready); end
    step();
    idle_in();
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL stall_next_valid got=%b want=1", bus.out_valid); end
    total++; if (bus.alu_out !== 64'd5) begin bad++; $display("FAIL stall_next_result got=%h want=5", bus.alu_out); end
    step();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL stall_drained got=%b want=0", bus.out_valid); end
  endtask

  task automatic test_reset_mid_mul();
    int spur = 0;
    put(64'd3, 64'd7, SRC_REG, ALU_ADD, 1'b1, 1'b1, COND_AL);
    step();
    idle_in();
    repeat (9) step();
    reset = 1'b1;
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rmul_out_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.flags !== 4'b0000) begin bad++; $display("FAIL rmul_flags got=%b want=0000", bus.flags); end
    step();
    reset = 1'b0;
    step();
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rmul_idle got=%b want=1", bus.in_ready); end
    for (int i = 0; i < 70; i++) begin
      if (bus.out_valid !== 1'b0) spur++;
      step();
    end
    total++; if (spur != 0) begin bad++; $display("FAIL rmul_spurious got=%0d cycles want=0", spur); end
    total++; if (bus.flags !== 4'b0000) begin bad++; $display("FAIL rmul_no_flag_update got=%b want=0000", bus.flags); end
    put(64'd2, 64'd2, SRC_REG, ALU_ADD, 1'b0, 1'b1, COND_AL);
    step();
    idle_in();
    total++; if (bus.alu_out !== 64'd4) begin bad++; $display("FAIL rmul_add got=%h want=4", bus.alu_out); end
    step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_%0d got=%b want=1", i, bus.in_ready); end
      put(64'(i), 64'd100, SRC_REG, ALU_ADD, 1'b0, 1'b0, 4'hE);
      step();
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid_%0d got=%b want=1", i, bus.out_valid); end
      total++; if (bus.alu_out !== 64'(i + 100)) begin bad++; $display("FAIL b2b_result_%0d got=%h want=%h", i, bus.alu_out, 64'(i + 100)); end
      total++; if (bus.cond_taken !== 1'b1) begin bad++; $display("FAIL b2b_cond_%0d got=%b want=1", i, bus.cond_taken); end
    end
    idle_in();
    step();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drained got=%b want=0", bus.out_valid); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    reset          = 1'b1;
    bus.in_valid   = 1'b0;
    bus.data_a     = '0;
    bus.data_b     = '0;
    bus.imm12_ext  = '0;
    bus.imm9_ext   = '0;
    bus.alu_src    = '0;
    bus.alu_op     = '0;
    bus.is_mul     = 1'b0;
    bus.flag_write = 1'b0;
    bus.cond       = '0;
    bus.out_ready  = 1'b1;
    test_reset();
    test_add_overflow();
    test_subs_cond();
    test_cond_table(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, ALU_ADD, 4'b0111, 16'hEA65);
    test_cond_table(64'd5, 64'd3, ALU_SUB, 4'b0100, 16'hD5A6);
    test_ops();
    test_mul();
    test_stall();
    test_reset_mid_mul();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
